// File: rtl/qadd_arb.sv
// Two-requester round-robin front end feeding a 3-stage a + 2*b pipeline.
// Results return on the requester's response port three unfrozen cycles after acceptance.
module qadd_arb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_c,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_c,
  output logic [1:0]       inflight,
  output logic             idle
);

  // last_q = 1 means requester 1 was granted most recently, so requester 0 wins a tie
  logic             last_q;
  logic             s1_v_q, s1_tag_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s2_v_q, s2_tag_q;
  logic [WIDTH-1:0] s2_sum_q, s2_b_q;
  logic             s3_v_q, s3_tag_q;
  logic [WIDTH-1:0] s3_c_q;
  logic [1:0]       inflight_q, inflight_d;

  logic             grant0, grant1, accept, resp_fire;
  logic [WIDTH-1:0] in_a, in_b;

  always_comb begin
    grant0    = rst && !hold && req0_valid && (!req1_valid || last_q);
    grant1    = rst && !hold && req1_valid && (!req0_valid || !last_q);
    accept    = grant0 || grant1;
    resp_fire = rst && !hold && s3_v_q;
    in_a      = grant1 ? req1_a : req0_a;
    in_b      = grant1 ? req1_b : req0_b;
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({accept, resp_fire})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q     <= 1'b1;
      s1_v_q     <= 1'b0;
      s1_tag_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_v_q     <= 1'b0;
      s2_tag_q   <= 1'b0;
      s2_sum_q   <= '0;
      s2_b_q     <= '0;
      s3_v_q     <= 1'b0;
      s3_tag_q   <= 1'b0;
      s3_c_q     <= '0;
      inflight_q <= 2'd0;
    end else if (!hold) begin
      if (accept) last_q <= grant1;
      s1_v_q     <= accept;
      s1_tag_q   <= grant1;
      s1_a_q     <= in_a;
      s1_b_q     <= in_b;
      s2_v_q     <= s1_v_q;
      s2_tag_q   <= s1_tag_q;
      s2_sum_q   <= s1_a_q + s1_b_q;
      s2_b_q     <= s1_b_q;
      s3_v_q     <= s2_v_q;
      s3_tag_q   <= s2_tag_q;
      s3_c_q     <= s2_sum_q + s2_b_q;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    req0_ready  = grant0;
    req1_ready  = grant1;
    resp0_valid = resp_fire && !s3_tag_q;
    resp1_valid = resp_fire && s3_tag_q;
    resp0_c     = rst ? s3_c_q : '0;
    resp1_c     = rst ? s3_c_q : '0;
    inflight    = inflight_q;
    idle        = (inflight_q == 2'd0) && !req0_valid && !req1_valid;
  end

endmodule

// File: tb/tb_qadd_arb.sv
// Scoreboard bench for qadd_arb: grants follow a round-robin model, results are queued
// at acceptance and must emerge three unfrozen cycles later in acceptance order.
module tb_qadd_arb;

  logic       clk = 1'b0;
  logic       rst, hold;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       resp0_valid, resp1_valid;
  logic [7:0] resp0_c, resp1_c;
  logic [1:0] inflight;
  logic       idle;

  qadd_arb #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp0_valid(resp0_valid),
    .resp0_c    (resp0_c),
    .resp1_valid(resp1_valid),
    .resp1_c    (resp1_c),
    .inflight   (inflight),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tag;
    logic [7:0] c;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   act = 0;      // count of unfrozen, out-of-reset cycles
  logic m_last = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic h, input logic v0, input logic [7:0] a0,
                       input logic [7:0] b0, input logic v1, input logic [7:0] a1,
                       input logic [7:0] b1);
    logic       g0, g1, er, e0, e1;
    logic [7:0] c0, c1;
    rst = r; hold = h;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    @(negedge clk);
    g0 = r && !h && v0 && (!v1 || m_last);
    g1 = r && !h && v1 && (!v0 || !m_last);
    check_eq("ready0", {31'b0, req0_ready}, {31'b0, g0});
    check_eq("ready1", {31'b0, req1_ready}, {31'b0, g1});
    if (r) begin
      check_eq("inflight", {30'b0, inflight}, q.size());
      check_eq("idle", {31'b0, idle}, {31'b0, (q.size() == 0) && !v0 && !v1});
    end
    er = r && !h && (q.size() > 0) && (q.size() > 0 ? q[0].due == act : 1'b0);
    e0 = er && !q[0].tag;
    e1 = er && q[0].tag;
    check_eq("resp0_valid", {31'b0, resp0_valid}, {31'b0, e0});
    check_eq("resp1_valid", {31'b0, resp1_valid}, {31'b0, e1});
    if (e0) check_eq("resp0_c", {24'b0, resp0_c}, {24'b0, q[0].c});
    if (e1) check_eq("resp1_c", {24'b0, resp1_c}, {24'b0, q[0].c});
    if (er) void'(q.pop_front());
    if (!r) begin
      q.delete();
      m_last = 1'b1;
    end else begin
      c0 = a0 + b0 + b0;
      c1 = a1 + b1 + b1;
      if (g0) q.push_back('{tag: 1'b0, c: c0, due: act + 3});
      if (g1) q.push_back('{tag: 1'b1, c: c1, due: act + 3});
      if (g0 || g1) m_last = g1;
      if (!h) act++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1;
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 3, 4, 1, 5, 6);
    check_eq("resp0_c_reset", {24'b0, resp0_c}, 32'd0);
    check_eq("resp1_c_reset", {24'b0, resp1_c}, 32'd0);

    // single requests, including an all-zero result
    cycle(1, 0, 1, 10, 5, 0, 0, 0);
    idle_cycles(4);
    cycle(1, 0, 0, 0, 0, 1, 200, 40);
    idle_cycles(4);
    cycle(1, 0, 1, 0, 0, 0, 0, 0);
    idle_cycles(4);

    // both requesters valid back to back from reset
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 8'(i), 8'(i + 1), 1, 8'(i + 100), 8'(i + 7));
    idle_cycles(4);

    // two ops in flight, frozen for two cycles
    cycle(1, 0, 1, 1, 2, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 3, 4);
    cycle(1, 1, 1, 9, 9, 1, 9, 9);
    cycle(1, 1, 1, 9, 9, 1, 9, 9);
    idle_cycles(5);

    // reset with three ops in flight
    cycle(1, 0, 1, 11, 12, 1, 13, 14);
    cycle(1, 0, 1, 15, 16, 1, 17, 18);
    cycle(1, 0, 1, 19, 20, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    idle_cycles(5);
    check_eq("idle_after_reset", {31'b0, idle}, 32'd1);

    // random traffic with occasional hold
    for (int i = 0; i < 300; i++)
      cycle(1, ($urandom_range(0, 4) == 0), 1'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 8'($urandom), 8'($urandom));
    idle_cycles(5);
    check_eq("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
